// File: rtl/sync_fifo_pkg.sv
// Shared types and width helpers for the synchronous FIFO controller.
// The optional error flags are enabled with the SYNC_FIFO_CTRL_ERR_EN macro.
package sync_fifo_pkg;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Count must hold DEPTH itself, and level must hold DEPTH+1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic ovf;
        logic udf;
    } fifo_err_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Increment-enable pointer for the FIFO RAM; wraps naturally at 2**W.
module fifo_wrap_ptr #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    logic [W-1:0] ptr_r;

    // Pointer register: cleared by reset, advances by one on each enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (inc) begin
            ptr_r <= ptr_r + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// FWFT FIFO controller driving an external two-port RAM (write on B, read on A).
// Define SYNC_FIFO_CTRL_ERR_EN to add the sticky ovf/udf error flags.
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   level,
    output logic                      ram_rena,
    output logic [addr_w(DEPTH)-1:0]  ram_addra,
    input  logic [WIDTH-1:0]          ram_douta,
    output logic                      ram_wenb,
    output logic [addr_w(DEPTH)-1:0]  ram_addrb,
    output logic [WIDTH-1:0]          ram_dinb
`ifdef SYNC_FIFO_CTRL_ERR_EN
    ,
    output logic                      ovf,
    output logic                      udf
`endif
);

    localparam int AW = addr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] ram_cnt_r;
    logic [CW-1:0] ram_cnt_next_s;
    logic          out_valid_r;
    logic [AW-1:0] wr_ptr_s;
    logic [AW-1:0] rd_ptr_s;
    logic          in_ready_s;
    logic          push_s;
    logic          pop_s;
    logic          rd_issue_s;

    fifo_wrap_ptr #(.W(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_s),
        .ptr (wr_ptr_s)
    );

    fifo_wrap_ptr #(.W(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (rd_issue_s),
        .ptr (rd_ptr_s)
    );

    // Handshake decode; ram_cnt only counts written, not-yet-read entries,
    // so a read can never hit the slot being written this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        rd_issue_s = 1'b0;
        in_ready_s = (ram_cnt_r != FULL_CNT);
        push_s     = in_valid & in_ready_s;
        pop_s      = out_valid_r & out_ready;
        rd_issue_s = (ram_cnt_r != {CW{1'b0}}) & (~out_valid_r | out_ready);
    end

    // Next RAM occupancy from the push/read-issue pair.
    always_comb begin
        ram_cnt_next_s = ram_cnt_r;
        case ({push_s, rd_issue_s})
            2'b10:   ram_cnt_next_s = ram_cnt_r + ONE_CNT;
            2'b01:   ram_cnt_next_s = ram_cnt_r - ONE_CNT;
            default: ram_cnt_next_s = ram_cnt_r;
        endcase
    end

    // RAM occupancy register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_cnt_r <= '0;
        end else begin
            ram_cnt_r <= ram_cnt_next_s;
        end
    end

    // Head-valid flag: a read issue refills the RAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (rd_issue_s) begin
            out_valid_r <= 1'b1;
        end else if (pop_s) begin
            out_valid_r <= 1'b0;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = ram_douta;
    assign level     = ram_cnt_r + {{(CW-1){1'b0}}, out_valid_r};
    assign ram_wenb  = push_s;
    assign ram_addrb = wr_ptr_s;
    assign ram_dinb  = in_data;
    assign ram_rena  = rd_issue_s;
    assign ram_addra = rd_ptr_s;

`ifdef SYNC_FIFO_CTRL_ERR_EN
    fifo_err_t err_r;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= '0;
        end else begin
            if (in_valid & ~in_ready_s) begin
                err_r.ovf <= 1'b1;
            end
            if (out_ready & (level == {CW{1'b0}})) begin
                err_r.udf <= 1'b1;
            end
        end
    end

    assign ovf = err_r.ovf;
    assign udf = err_r.udf;
`endif

endmodule
